buton_debounce: RTL and testbench
=================================

BUTON_DEBOUNCE -- requirements
Module: buton_debounce

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 3, meaning the number of consecutive equal synchronized samples needed to accept a new button level (legal range 1..15).
REQ-002 SHALL have parameter CNT_W, default 4, meaning the debounce counter width, with 2**CNT_W > STABLE_CYCLES.
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port buton  input  1  raw pedestrian push-button, asynchronous, may bounce or be X before reset release.
REQ-006 SHALL have port cerere_ack  input  1  one-cycle acknowledge from the downstream semafor block that the pending request was consumed.
REQ-007 SHALL have port buton_stabil  output  1  debounced button level.
REQ-008 SHALL have port apasare  output  1  single-cycle pulse on each accepted press (0->1 of buton_stabil).
REQ-009 SHALL have port cerere  output  1  sticky pedestrian request level driven to the semafor buton input.

Function
REQ-010 SHALL pass buton through a 2-flop synchronizer; only its second-stage output (sync) is used by the rest of the logic.
REQ-011 SHALL implement FSM states IDLE, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE.
REQ-012 IDLE: sync=1 -> CONFIRM_PRESS with counter=1; sync=0 -> stay, counter=0.
REQ-013 CONFIRM_PRESS: sync=1 and counter=STABLE_CYCLES-1 -> PRESSED; sync=1 otherwise -> counter+1; sync=0 -> IDLE, counter=0 (bounce rejected, no output change).
REQ-014 PRESSED: sync=0 -> CONFIRM_RELEASE with counter=1; sync=1 -> stay.
REQ-015 CONFIRM_RELEASE: sync=0 and counter=STABLE_CYCLES-1 -> IDLE; sync=0 otherwise -> counter+1; sync=1 -> PRESSED, counter=0.
REQ-016 For STABLE_CYCLES=1, the confirm states SHALL be left on their first sample (a single sample accepts the level).
REQ-017 buton_stabil SHALL be 1 exactly in states PRESSED and CONFIRM_RELEASE, registered.
REQ-018 apasare SHALL be 1 for exactly one cycle, the first cycle buton_stabil is 1; a stable press at buton yields apasare 2+STABLE_CYCLES rising edges after the first edge sampling buton=1.
REQ-019 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-020 cerere SHALL set to 1 on the edge after apasare=1 and clear on the edge after cerere_ack=1.
REQ-021 Simultaneous apasare=1 and cerere_ack=1 SHALL leave cerere=1 (new press wins).
REQ-022 cerere_ack with cerere=0 SHALL be ignored; repeated presses while cerere=1 SHALL keep cerere=1 (no counting, no queueing).
REQ-023 A press held indefinitely SHALL produce one apasare and no further pulses until a confirmed release.

Reset
REQ-024 rst_n=0 SHALL immediately force synchronizer flops=0, state=IDLE, counter=0, buton_stabil=0, apasare=0, cerere=0.
REQ-025 Reset asserted mid-press or mid-confirm SHALL discard the press; after release a held button SHALL be re-confirmed from IDLE and yield a new apasare.
REQ-026 X on buton during reset SHALL NOT propagate to any output after reset release once buton is driven 0/1.

Structure
REQ-027 FSM state encoding (2 bits) and STABLE_CYCLES/CNT_W defaults SHALL live in the shared semafor package/include file, also used by semafor.
REQ-028 The synchronizer SHALL be a separate sub-module sync_2ff (clk, rst_n, d, q), reset value 0.
REQ-029 buton_debounce.cerere SHALL connect to semafor.buton; cerere_ack SHALL be driven by semafor when it starts the pedestrian phase.

Verification
REQ-030 STABLE_CYCLES=3, buton 0->1 held 10 cycles -> apasare single pulse at edge 5 after first 1-sample, buton_stabil=1, cerere=1 next edge.
REQ-031 buton pulses 1 for 1, 2, then 2 cycles with 1-cycle gaps -> apasare never asserts, buton_stabil stays 0, cerere stays 0.
REQ-032 Press accepted, release bounces 0/1/0 single cycles, then 0 held -> buton_stabil stays 1 through bounce, falls 2+3 edges after the final 0 begins, no extra apasare.
REQ-033 cerere=1, cerere_ack pulse -> cerere=0 next edge; apasare and cerere_ack in same cycle -> cerere=1.
REQ-034 rst_n asserted asynchronously between clk edges while in CONFIRM_PRESS with buton=1 -> all outputs 0 immediately; after release, buton held 1 -> fresh apasare after 2+3 edges.
REQ-035 Sweep STABLE_CYCLES in {1,3,15} with random bounce stimulus -> apasare count equals number of 1-runs of sync lasting >= STABLE_CYCLES that are separated by 0-runs lasting >= STABLE_CYCLES.

Source files
------------

// File: rtl/buton_debounce_pkg.sv
// ---------------------------------------------------------------------------
// buton_debounce_pkg
//   Shared definitions for the pedestrian push-button debouncer. The semafor
//   block imports the same package, so both agree on the debouncer state
//   encoding and on the default debounce depth.
//
//   Contents:
//     state_t             2-bit debouncer FSM state type
//     ST_*                FSM state encodings
//     STABLE_CYCLES_DEF   default number of equal samples to accept a level
//     CNT_W_DEF           default debounce counter width
//     isStable()          debounced level implied by an FSM state
// ---------------------------------------------------------------------------
package buton_debounce_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE            = 2'd0;
  localparam logic [1:0] ST_CONFIRM_PRESS   = 2'd1;
  localparam logic [1:0] ST_PRESSED         = 2'd2;
  localparam logic [1:0] ST_CONFIRM_RELEASE = 2'd3;

  localparam int STABLE_CYCLES_DEF = 3;
  localparam int CNT_W_DEF         = 4;

  // The button counts as held from acceptance of a press until a release
  // has been fully confirmed, so the release-confirm state still reads 1.
  function automatic logic isStable(input state_t st);
    return (st == ST_PRESSED) || (st == ST_CONFIRM_RELEASE);
  endfunction

endpackage

// File: rtl/buton_debounce_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer bringing the asynchronous raw button into the clk
//   domain. Both stages clear to 0 in reset so an undriven button cannot
//   leak an unknown value downstream.
//
//   Ports:
//     clk    input   system clock, rising edge
//     rst_n  input   asynchronous active-low reset
//     d      input   asynchronous data in
//     q      output  synchronized data (second stage)
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // The first stage may go metastable; only the second stage is exposed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/buton_debounce.sv
// ---------------------------------------------------------------------------
// buton_debounce
//   Debounces the pedestrian push-button and turns each accepted press into
//   a sticky request for the semafor block. A new level is accepted only
//   after STABLE_CYCLES consecutive equal synchronized samples.
//
//   Parameters:
//     STABLE_CYCLES  equal samples needed to accept a new level (1..15)
//     CNT_W          debounce counter width, 2**CNT_W > STABLE_CYCLES
//
//   Ports:
//     clk           input   system clock, rising edge
//     rst_n         input   asynchronous active-low reset
//     buton         input   raw asynchronous push-button
//     cerere_ack    input   one-cycle acknowledge from semafor
//     buton_stabil  output  debounced button level
//     apasare       output  one-cycle pulse per accepted press
//     cerere        output  sticky pedestrian request to semafor
// ---------------------------------------------------------------------------
module buton_debounce
  import buton_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic buton,
  input  logic cerere_ack,
  output logic buton_stabil,
  output logic apasare,
  output logic cerere
);

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);
  // With a depth of one the first differing sample already accepts the
  // level, so the confirm states are bypassed and the counter stays at 0.
  localparam bit SingleSample = (STABLE_CYCLES == 1);

  logic             sync;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stabil_q, stabil_d;
  logic             apasare_q, apasare_d;
  logic             cerere_q, cerere_d;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (buton),
    .q     (sync)
  );

  // Debounce FSM. The counter holds how many equal samples of the candidate
  // level have been seen; reaching the last count on another equal sample
  // accepts the level, so it never passes STABLE_CYCLES-1 and cannot wrap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    apasare_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync) begin
          if (SingleSample) begin
            state_d   = ST_PRESSED;
            cnt_d     = '0;
            apasare_d = 1'b1;
          end else begin
            state_d = ST_CONFIRM_PRESS;
            cnt_d   = CntOne;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_CONFIRM_PRESS: begin
        if (sync) begin
          if (cnt_q >= CntLast) begin
            state_d   = ST_PRESSED;
            cnt_d     = '0;
            apasare_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_PRESSED: begin
        if (!sync) begin
          if (SingleSample) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_CONFIRM_RELEASE;
            cnt_d   = CntOne;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_CONFIRM_RELEASE: begin
        if (!sync) begin
          if (cnt_q >= CntLast) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end else begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The debounced level is decoded from the next state so it is registered
  // in step with the FSM. A press that coincides with an acknowledge keeps
  // the request set: a fresh press must not be lost.
  always_comb begin
    stabil_d = isStable(state_d);
    cerere_d = apasare_q | (cerere_q & ~cerere_ack);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      stabil_q  <= 1'b0;
      apasare_q <= 1'b0;
      cerere_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stabil_q  <= stabil_d;
      apasare_q <= apasare_d;
      cerere_q  <= cerere_d;
    end
  end

  assign buton_stabil = stabil_q;
  assign apasare      = apasare_q;
  assign cerere       = cerere_q;

endmodule

// File: tb/tb_buton_debounce.sv
// ---------------------------------------------------------------------------
// tb_buton_debounce
//   Bench for buton_debounce. Three instances (depths 1, 3 and 15) share the
//   button, acknowledge and reset. A reference model tracks, per depth, the
//   accepted level as "flip once N consecutive differing samples were seen",
//   fed through a two-sample delay queue, and the request as a set/clear
//   latch driven by the model's own press pulses.
// ---------------------------------------------------------------------------
module tb_buton_debounce;

  typedef struct {
    logic b;
    logic a;
    logic eStab;
    logic eAp;
    logic eCer;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       buton;
  logic       ack;
  logic [2:0] stabil;
  logic [2:0] ap;
  logic [2:0] cer;

  int nChecks = 0;
  int nFails  = 0;

  int sTab[3] = '{1, 3, 15};
  bit lvl[3];
  int run[3];
  bit apM[3];
  bit cerM[3];
  int apCntM[3];
  int apCntD[3];
  bit bq[$];

  vec_t tbl[13];

  buton_debounce #(.STABLE_CYCLES(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .buton(buton), .cerere_ack(ack),
    .buton_stabil(stabil[0]), .apasare(ap[0]), .cerere(cer[0])
  );

  buton_debounce dut3 (
    .clk(clk), .rst_n(rst_n), .buton(buton), .cerere_ack(ack),
    .buton_stabil(stabil[1]), .apasare(ap[1]), .cerere(cer[1])
  );

  buton_debounce #(.STABLE_CYCLES(15), .CNT_W(4)) dut15 (
    .clk(clk), .rst_n(rst_n), .buton(buton), .cerere_ack(ack),
    .buton_stabil(stabil[2]), .apasare(ap[2]), .cerere(cer[2])
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Hard stop in case something stalls the flow.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic act, input logic exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    bq.delete();
    for (int j = 0; j < 3; j++) begin
      lvl[j]  = 1'b0;
      run[j]  = 0;
      apM[j]  = 1'b0;
      cerM[j] = 1'b0;
    end
  endtask

  // One clock edge of the reference model, using the inputs held across it.
  task automatic modelEdge();
    bit s;
    bq.push_back(buton === 1'b1);
    if (bq.size() > 2) s = bq.pop_front();
    else               s = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cerM[j] = apM[j] | (cerM[j] & !(ack === 1'b1));
      apM[j]  = 1'b0;
      if (s != lvl[j]) begin
        run[j]++;
        if (run[j] == sTab[j]) begin
          lvl[j] = s;
          run[j] = 0;
          if (s) begin
            apM[j] = 1'b1;
            apCntM[j]++;
          end
        end
      end else begin
        run[j] = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, advance one edge, compare every instance.
  task automatic applyStimulus(input logic b, input logic a);
    buton = b;
    ack   = a;
    @(posedge clk);
    modelEdge();
    #1;
    for (int j = 0; j < 3; j++) begin
      checkOutput($sformatf("stabil S=%0d", sTab[j]), stabil[j], lvl[j]);
      checkOutput($sformatf("apasare S=%0d", sTab[j]), ap[j], apM[j]);
      checkOutput($sformatf("cerere S=%0d", sTab[j]), cer[j], cerM[j]);
      if (ap[j] === 1'b1) apCntD[j]++;
    end
  endtask

  // Assert reset between edges, check outputs clear at once, then release.
  task automatic doReset(input logic bAfter);
    #2;
    rst_n = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) begin
      checkOutput($sformatf("reset stabil S=%0d", sTab[j]), stabil[j], 1'b0);
      checkOutput($sformatf("reset apasare S=%0d", sTab[j]), ap[j], 1'b0);
      checkOutput($sformatf("reset cerere S=%0d", sTab[j]), cer[j], 1'b0);
    end
    modelReset();
    repeat (2) @(posedge clk);
    buton = bAfter;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int found;
    int apBase;
    int lvlR;
    int left;

    rst_n = 1'b1;
    buton = 1'bx;
    ack   = 1'b0;
    for (int j = 0; j < 3; j++) begin
      apCntM[j] = 0;
      apCntD[j] = 0;
    end

    // Expected behaviour of the depth-3 instance for a clean press, an
    // acknowledge, a clean release and a stray acknowledge.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    $display("[TB] reset with undriven button");
    doReset(1'b0);

    $display("[TB] vector table");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].b, tbl[i].a);
      checkOutput($sformatf("tbl[%0d] stabil", i), stabil[1], tbl[i].eStab);
      checkOutput($sformatf("tbl[%0d] apasare", i), ap[1], tbl[i].eAp);
      checkOutput($sformatf("tbl[%0d] cerere", i), cer[1], tbl[i].eCer);
    end

    $display("[TB] short bounces are rejected");
    repeat (20) applyStimulus(1'b0, 1'b0);
    apBase = apCntD[1];
    begin
      logic [13:0] pat;
      pat = 14'b10110110000000;
      for (int i = 13; i >= 0; i--) begin
        applyStimulus(pat[i], 1'b0);
        checkOutput("bounce stabil", stabil[1], 1'b0);
        checkOutput("bounce cerere", cer[1], 1'b0);
      end
    end
    checkInt("bounce apasare count", apCntD[1] - apBase, 0);

    $display("[TB] press, bouncy release, press racing acknowledge");
    repeat (8) applyStimulus(1'b1, 1'b0);
    checkOutput("held press stabil", stabil[1], 1'b1);
    checkOutput("held press cerere", cer[1], 1'b1);
    apBase = apCntD[1];
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    found = 0;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 1'b0);
      if (found == 0 && stabil[1] === 1'b0) found = k;
    end
    checkInt("release fall edge", found, 5);
    checkInt("release extra apasare", apCntD[1] - apBase, 0);
    checkOutput("cerere held through release", cer[1], 1'b1);
    for (int k = 1; k <= 5; k++) applyStimulus(1'b1, 1'b0);
    checkOutput("press apasare at edge 5", ap[1], 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("ack with press keeps cerere", cer[1], 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("ack clears cerere", cer[1], 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("ack while idle ignored", cer[1], 1'b0);
    apBase = apCntD[1];
    repeat (30) applyStimulus(1'b1, 1'b0);
    checkInt("long hold single pulse", apCntD[1] - apBase, 0);

    $display("[TB] reset in the middle of a press confirmation");
    repeat (8) applyStimulus(1'b0, 1'b0);
    repeat (6) applyStimulus(1'b1, 1'b0);
    repeat (8) applyStimulus(1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("pre-reset cerere", cer[1], 1'b1);
    doReset(1'b1);
    found = 0;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (found == 0 && ap[1] === 1'b1) found = k;
    end
    checkInt("post-reset press latency", found, 5);

    $display("[TB] random bounce sweep");
    repeat (40) applyStimulus(1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      apCntM[j] = 0;
      apCntD[j] = 0;
    end
    lvlR = 0;
    left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (left == 0) begin
        lvlR = 1 - lvlR;
        left = $urandom_range(1, 35);
      end
      left--;
      applyStimulus(lvlR[0], ($urandom_range(0, 7) == 0));
    end
    repeat (40) applyStimulus(1'b0, 1'b0);
    for (int j = 0; j < 3; j++)
      checkInt($sformatf("random apasare count S=%0d", sTab[j]), apCntD[j], apCntM[j]);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
